// File: rtl/bit_packer.sv
// bit_packer: packs MSB-first variable-length Huffman codes into OUT_WIDTH-bit
// flash words, with optional JPEG 0x00 stuffing after 0xFF bytes, 1s padding
// of the final byte and byte enables on the last partial word of a frame.
// ACC_WIDTH is expected to be a multiple of 8 so the byte-rounded fill level
// always fits the accumulator.
module bit_packer #(
    parameter int OUT_WIDTH    = 32,
    parameter int MAX_CODE_LEN = 32,
    parameter int ACC_WIDTH    = 64,
    parameter bit STUFF_EN     = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [MAX_CODE_LEN-1:0]  code_in,
    input  logic [5:0]               len_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     eof_in,
    input  logic                     s_halt,
    output logic [OUT_WIDTH-1:0]     d_out,
    output logic [OUT_WIDTH/8-1:0]   be_out,
    output logic                     d_qual,
    output logic                     eof_out,
    output logic [31:0]              bytes_out
);

    localparam int NB = OUT_WIDTH / 8;
    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam int LW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2,
        LAST  = 2'd3
    } state_t;

    state_t                  state;

    // Bit accumulator: oldest bit lives at the MSB, acc_count bits are valid.
    logic [ACC_WIDTH-1:0]    acc;
    logic [CW-1:0]           acc_count;
    logic                    stuff_pending;

    // Word assembler: lanes fill from NB-1 downward.
    logic [OUT_WIDTH-1:0]    asm_word;
    logic [LW-1:0]           asm_lanes;

    // Set once a frame's final word is consumed, so the next frame's first
    // accepted beat knows to restart the byte counter.
    logic                    frame_done;

    logic                    asm_full;
    logic                    out_free;
    logic                    have_byte;
    logic                    extract;
    logic                    from_acc;
    logic [7:0]              byte_val;
    logic                    beat_take;
    logic                    eof_take;
    logic [NB-1:0]           lane_be;
    logic [OUT_WIDTH-1:0]    lane_byte;

    logic [ACC_WIDTH-1:0]    acc_shift;
    logic [CW-1:0]           count_shift;
    logic [MAX_CODE_LEN-1:0] code_masked;
    logic [ACC_WIDTH-1:0]    code_ext;
    logic [CW-1:0]           place_shift;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic [CW-1:0]           count_next;
    logic [CW-1:0]           pad_round;
    logic [ACC_WIDTH-1:0]    pad_mask;

    assign in_ready  = !rst && (state == RUN) &&
                       (acc_count <= CW'(ACC_WIDTH - MAX_CODE_LEN));
    assign beat_take = in_valid && in_ready;
    assign eof_take  = eof_in && in_ready;

    // The assembler may hand a word on only when the output register is
    // empty or is being consumed in this very cycle.
    assign asm_full  = (asm_lanes == LW'(NB));
    assign out_free  = !d_qual || !s_halt;

    // A pending stuff byte always wins over the next accumulator byte.
    assign have_byte = ((state == RUN) || (state == DRAIN)) &&
                       (stuff_pending || (acc_count >= CW'(8)));
    assign extract   = have_byte && (!asm_full || out_free);
    assign from_acc  = extract && !stuff_pending;
    assign byte_val  = stuff_pending ? 8'h00 : acc[ACC_WIDTH-1 -: 8];

    // Filled lanes of a partial word are contiguous from the top lane.
    assign lane_be   = ~({NB{1'b1}} >> asm_lanes);

    // Place the extracted byte into the next free assembler lane.
    always_comb begin
        lane_byte = '0;
        if (!asm_full) begin
            lane_byte = {{(OUT_WIDTH-8){1'b0}}, byte_val}
                        << (8 * (NB - 1 - int'(asm_lanes)));
        end
    end

    // Next accumulator content: drop the extracted byte, then append the
    // accepted code directly below whatever bits remain.
    always_comb begin
        acc_shift   = from_acc ? (acc << 8) : acc;
        count_shift = from_acc ? (acc_count - CW'(8)) : acc_count;
        code_masked = code_in & ~({MAX_CODE_LEN{1'b1}} << len_in);
        code_ext    = {{(ACC_WIDTH-MAX_CODE_LEN){1'b0}}, code_masked};
        place_shift = CW'(ACC_WIDTH) - count_shift - CW'(len_in);
        acc_next    = acc_shift;
        count_next  = count_shift;
        if (beat_take) begin
            acc_next   = acc_shift | (code_ext << place_shift);
            count_next = count_shift + CW'(len_in);
        end
    end

    // End-of-frame padding: 1s from the current fill level to the next byte
    // boundary, leaving an already aligned accumulator untouched.
    always_comb begin
        pad_round = (acc_count[2:0] == 3'd0) ? acc_count
                                             : ((acc_count | CW'(7)) + CW'(1));
        pad_mask  = ({ACC_WIDTH{1'b1}} >> acc_count) &
                    ~({ACC_WIDTH{1'b1}} >> pad_round);
    end

    // Datapath, frame state machine and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= RUN;
            acc           <= '0;
            acc_count     <= '0;
            stuff_pending <= 1'b0;
            asm_word      <= '0;
            asm_lanes     <= '0;
            frame_done    <= 1'b0;
            d_out         <= '0;
            be_out        <= '0;
            d_qual        <= 1'b0;
            eof_out       <= 1'b0;
            bytes_out     <= '0;
        end else begin
            if (state == PAD) begin
                acc       <= acc | pad_mask;
                acc_count <= pad_round;
            end else begin
                acc       <= acc_next;
                acc_count <= count_next;
            end

            if (extract) begin
                stuff_pending <= STUFF_EN && !stuff_pending && (byte_val == 8'hFF);
            end

            if ((state == RUN) && (beat_take || eof_take) && frame_done) begin
                bytes_out  <= '0;
                frame_done <= 1'b0;
            end else if (extract) begin
                bytes_out <= bytes_out + 32'd1;
            end

            case (state)
                RUN, PAD, DRAIN: begin
                    // A full word is only released once a following byte
                    // exists, so the frame's last word can still carry eof.
                    if (extract && asm_full) begin
                        d_out     <= asm_word;
                        be_out    <= '1;
                        d_qual    <= 1'b1;
                        eof_out   <= 1'b0;
                        asm_word  <= {byte_val, {(OUT_WIDTH-8){1'b0}}};
                        asm_lanes <= LW'(1);
                    end else begin
                        if (d_qual && !s_halt) begin
                            d_qual  <= 1'b0;
                            eof_out <= 1'b0;
                        end
                        if (extract) begin
                            asm_word  <= asm_word | lane_byte;
                            asm_lanes <= asm_lanes + LW'(1);
                        end
                    end

                    if ((state == RUN) && eof_take) begin
                        state <= PAD;
                    end else if (state == PAD) begin
                        state <= DRAIN;
                    end else if ((state == DRAIN) && (acc_count == '0) && !stuff_pending) begin
                        state <= LAST;
                    end
                end

                LAST: begin
                    if (d_qual && eof_out) begin
                        if (!s_halt) begin
                            d_qual     <= 1'b0;
                            eof_out    <= 1'b0;
                            asm_word   <= '0;
                            asm_lanes  <= '0;
                            frame_done <= 1'b1;
                            state      <= RUN;
                        end
                    end else if (out_free) begin
                        d_out   <= asm_word;
                        be_out  <= lane_be;
                        d_qual  <= 1'b1;
                        eof_out <= 1'b1;
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: scoreboard bench for bit_packer (OUT_WIDTH=32), plus a
// second instance with stuffing disabled.
module tb_bit_packer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] code_in = '0;
    logic [5:0]  len_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        eof_in = 1'b0;
    logic        s_halt = 1'b0;
    logic [31:0] d_out;
    logic [3:0]  be_out;
    logic        d_qual;
    logic        eof_out;
    logic [31:0] bytes_out;

    logic        ns_rst = 1'b1;
    logic [31:0] ns_code = '0;
    logic [5:0]  ns_len = '0;
    logic        ns_valid = 1'b0;
    logic        ns_ready;
    logic        ns_eof = 1'b0;
    logic        ns_halt = 1'b0;
    logic [31:0] ns_d;
    logic [3:0]  ns_be;
    logic        ns_qual;
    logic        ns_eof_out;
    logic [31:0] ns_bytes;

    int          check_count = 0;
    int          pass_count = 0;
    int          halt_left = 0;
    bit          halt_rand = 1'b0;
    int          stall_cycles = 0;

    logic [36:0] sb[$];
    logic [36:0] held;
    bit          held_v = 1'b0;

    always #5 clk_in = ~clk_in;

    bit_packer #(.OUT_WIDTH(32), .MAX_CODE_LEN(32), .ACC_WIDTH(64), .STUFF_EN(1'b1)) dut (
        .clk_in(clk_in), .rst(rst), .code_in(code_in), .len_in(len_in),
        .in_valid(in_valid), .in_ready(in_ready), .eof_in(eof_in), .s_halt(s_halt),
        .d_out(d_out), .be_out(be_out), .d_qual(d_qual), .eof_out(eof_out),
        .bytes_out(bytes_out)
    );

    bit_packer #(.OUT_WIDTH(32), .MAX_CODE_LEN(32), .ACC_WIDTH(64), .STUFF_EN(1'b0)) dut_ns (
        .clk_in(clk_in), .rst(ns_rst), .code_in(ns_code), .len_in(ns_len),
        .in_valid(ns_valid), .in_ready(ns_ready), .eof_in(ns_eof), .s_halt(ns_halt),
        .d_out(ns_d), .be_out(ns_be), .d_qual(ns_qual), .eof_out(ns_eof_out),
        .bytes_out(ns_bytes)
    );

    // Flash stall generator: a forced burst first, then optional random stalls.
    always @(posedge clk_in) begin
        #1;
        if (halt_left > 0) begin
            s_halt = 1'b1;
            halt_left--;
        end else if (halt_rand) begin
            s_halt = ($urandom_range(0, 3) != 0);
        end else begin
            s_halt = 1'b0;
        end
    end

    // Illegal code lengths must never be offered to the packer.
    always @(negedge clk_in) begin
        if (!rst && in_valid && in_ready) begin
            assert (len_in <= 6'd32) else $error("[TB] illegal len_in %0d", len_in);
        end
    end

    // Output monitor: checks words against the scoreboard on consumption and
    // checks that a halted word stays put.
    always @(negedge clk_in) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check_count++;
                if ({d_qual, d_out, be_out, eof_out} !== {1'b1, held}) begin
                    $display("[TB] FAIL halt_stable got q=%b %h/%b/%b required q=1 %h/%b/%b",
                             d_qual, d_out, be_out, eof_out, held[36:5], held[4:1], held[0]);
                end else begin
                    pass_count++;
                end
            end
            held_v = 1'b0;
            if (d_qual) begin
                if (s_halt) begin
                    held   = {d_out, be_out, eof_out};
                    held_v = 1'b1;
                end else begin
                    check_count++;
                    if (sb.size() == 0) begin
                        $display("[TB] FAIL word_unexpected got %h/%b/%b required no word",
                                 d_out, be_out, eof_out);
                    end else begin
                        logic [36:0] exp;
                        exp = sb.pop_front();
                        if ({d_out, be_out, eof_out} !== exp) begin
                            $display("[TB] FAIL word got %h/%b/%b required %h/%b/%b",
                                     d_out, be_out, eof_out, exp[36:5], exp[4:1], exp[0]);
                        end else begin
                            pass_count++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send(input logic v, input logic [31:0] code, input logic [5:0] len,
                        input logic eof);
        bit done = 1'b0;
        in_valid = v;
        code_in  = code;
        len_in   = len;
        eof_in   = eof;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk_in);
            if (in_ready) done = 1'b1;
            else if (v) stall_cycles++;
        end
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        eof_in   = 1'b0;
        code_in  = '0;
        len_in   = '0;
        if (!done) begin
            check_count++;
            $display("[TB] FAIL send_timeout got in_ready=0 required 1");
        end
    endtask

    task automatic ns_send(input logic v, input logic [31:0] code, input logic [5:0] len,
                           input logic eof);
        bit done = 1'b0;
        ns_valid = v;
        ns_code  = code;
        ns_len   = len;
        ns_eof   = eof;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk_in);
            if (ns_ready) done = 1'b1;
        end
        @(posedge clk_in);
        #1;
        ns_valid = 1'b0;
        ns_eof   = 1'b0;
        if (!done) begin
            check_count++;
            $display("[TB] FAIL ns_send_timeout got ns_ready=0 required 1");
        end
    endtask

    task automatic wait_frame_end();
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk_in);
            if (sb.size() == 0) done = 1'b1;
        end
        repeat (2) @(posedge clk_in);
        #1;
        if (!done) begin
            check_count++;
            $display("[TB] FAIL frame_timeout got %0d words pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        ns_rst = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b required 0", in_ready);
        else pass_count++;
        check_count++;
        if ({d_out, be_out, d_qual, eof_out, bytes_out} !== 69'd0)
            $display("[TB] FAIL reset_outputs got %h/%b/%b/%b/%0d required all 0",
                     d_out, be_out, d_qual, eof_out, bytes_out);
        else pass_count++;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        ns_rst = 1'b0;
        @(negedge clk_in);
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_reset got %b required 1", in_ready);
        else pass_count++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        sb.push_back({32'h12345678, 4'b1111, 1'b1});
        send(1'b1, 32'h12, 6'd8, 1'b0);
        send(1'b1, 32'h34, 6'd8, 1'b0);
        send(1'b1, 32'h56, 6'd8, 1'b0);
        send(1'b1, 32'h78, 6'd8, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd4) $display("[TB] FAIL basic_bytes got %0d required 4", bytes_out);
        else pass_count++;
    endtask

    task automatic test_stuffing();
        $display("[TB] test_stuffing");
        sb.push_back({32'hFF000100, 4'b1110, 1'b1});
        send(1'b1, 32'hFF, 6'd8, 1'b0);
        check_count++;
        if (bytes_out !== 32'd0) $display("[TB] FAIL bytes_cleared got %0d required 0", bytes_out);
        else pass_count++;
        send(1'b1, 32'h01, 6'd8, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd3) $display("[TB] FAIL stuff_bytes got %0d required 3", bytes_out);
        else pass_count++;
    endtask

    task automatic test_no_stuff();
        bit seen = 1'b0;
        $display("[TB] test_no_stuff");
        ns_send(1'b1, 32'hFF, 6'd8, 1'b0);
        ns_send(1'b1, 32'h01, 6'd8, 1'b0);
        ns_send(1'b0, 32'h0, 6'd0, 1'b1);
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_in);
            if (ns_qual) seen = 1'b1;
        end
        check_count++;
        if (!seen) begin
            $display("[TB] FAIL ns_word_timeout got no word required one");
        end else if ({ns_d, ns_be, ns_eof_out} !== {32'hFF010000, 4'b1100, 1'b1}) begin
            $display("[TB] FAIL ns_word got %h/%b/%b required ff010000/1100/1",
                     ns_d, ns_be, ns_eof_out);
        end else begin
            pass_count++;
        end
        check_count++;
        if (ns_bytes !== 32'd2) $display("[TB] FAIL ns_bytes got %0d required 2", ns_bytes);
        else pass_count++;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic test_padding();
        $display("[TB] test_padding");
        sb.push_back({32'hBF000000, 4'b1000, 1'b1});
        send(1'b1, 32'h5, 6'd3, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd1) $display("[TB] FAIL pad_bytes got %0d required 1", bytes_out);
        else pass_count++;
    endtask

    task automatic test_pad_ff();
        $display("[TB] test_pad_ff");
        sb.push_back({32'hFF000000, 4'b1100, 1'b1});
        send(1'b1, 32'hF, 6'd4, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd2) $display("[TB] FAIL pad_ff_bytes got %0d required 2", bytes_out);
        else pass_count++;
    endtask

    task automatic test_mixed_lengths();
        $display("[TB] test_mixed_lengths");
        sb.push_back({32'hFEB6AF37, 4'b1111, 1'b1});
        send(1'b1, 32'hFFFFFFFF, 6'd2, 1'b0);
        send(1'b1, 32'h00000000, 6'd0, 1'b0);
        send(1'b1, 32'hA5A5A1F5, 6'd9, 1'b0);
        send(1'b1, 32'hFFFFFFFD, 6'd3, 1'b0);
        send(1'b1, 32'h1234ABCD, 6'd16, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd4) $display("[TB] FAIL mixed_bytes got %0d required 4", bytes_out);
        else pass_count++;
    endtask

    task automatic test_empty_frame();
        $display("[TB] test_empty_frame");
        sb.push_back({32'h00000000, 4'b0000, 1'b1});
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd0) $display("[TB] FAIL empty_bytes got %0d required 0", bytes_out);
        else pass_count++;
    endtask

    task automatic test_back_pressure();
        $display("[TB] test_back_pressure");
        for (int i = 0; i < 15; i++) sb.push_back({32'hA5A5A5A5, 4'b1111, 1'b0});
        sb.push_back({32'hA5A5A5A5, 4'b1111, 1'b1});
        stall_cycles = 0;
        halt_left = 30;
        halt_rand = 1'b1;
        for (int i = 0; i < 64; i++) send(1'b1, 32'hA5, 6'd8, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        halt_rand = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_count++;
        if (stall_cycles == 0) $display("[TB] FAIL bp_ready_drop got 0 stall cycles required >0");
        else pass_count++;
        check_count++;
        if (bytes_out !== 32'd64) $display("[TB] FAIL bp_bytes got %0d required 64", bytes_out);
        else pass_count++;
    endtask

    task automatic test_reset_mid_frame();
        $display("[TB] test_reset_mid_frame");
        send(1'b1, 32'h11, 6'd8, 1'b0);
        send(1'b1, 32'h22, 6'd8, 1'b0);
        send(1'b1, 32'h33, 6'd8, 1'b0);
        rst = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check_count++;
        if ({d_out, be_out, d_qual, eof_out, bytes_out} !== 69'd0)
            $display("[TB] FAIL midreset_outputs got %h/%b/%b/%b/%0d required all 0",
                     d_out, be_out, d_qual, eof_out, bytes_out);
        else pass_count++;
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL midreset_ready got %b required 0", in_ready);
        else pass_count++;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        sb.push_back({32'hAB000000, 4'b1000, 1'b1});
        send(1'b1, 32'hAB, 6'd8, 1'b0);
        send(1'b0, 32'h0, 6'd0, 1'b1);
        wait_frame_end();
        check_count++;
        if (bytes_out !== 32'd1) $display("[TB] FAIL midreset_bytes got %0d required 1", bytes_out);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuffing();
        test_no_stuff();
        test_padding();
        test_pad_ff();
        test_mixed_lengths();
        test_empty_frame();
        test_back_pressure();
        test_reset_mid_frame();
        repeat (4) @(posedge clk_in);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Parametrised successor to the Huffman-FIFO-to-flash output path of the encoder.
- Accepts variable-length Huffman codes, MSB-first, and packs them into OUT_WIDTH-bit flash words.
- Inserts JPEG 0x00 stuffing after every emitted 0xFF byte (optional), pads the final byte with 1s on end-of-frame, and marks the last partial word with byte enables.
- Sits between the Huffman stage and the flash writer, honouring flash back-pressure (s_halt).

Parameters:
OUT_WIDTH, 32, output word width in bits; multiple of 8, minimum 16; NB = OUT_WIDTH/8 byte lanes.
MAX_CODE_LEN, 32, maximum code length per input beat; at most 32.
ACC_WIDTH, 64, bit-accumulator depth; at least MAX_CODE_LEN+8.
STUFF_EN, 1, 1 = insert 0x00 after each 0xFF byte; 0 = no stuffing.

Ports:
clk_in  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
code_in  in  MAX_CODE_LEN  code bits, right-aligned; bits above len_in are ignored.
len_in  in  6  code length 0..MAX_CODE_LEN; 0 = no-op beat.
in_valid  in  1  code beat valid.
in_ready  out  1  packer can accept a beat this cycle.
eof_in  in  1  end of frame, sampled only when in_valid&&in_ready or (!in_valid&&in_ready).
s_halt  in  1  flash stall; while high the output word is held.
d_out  out  OUT_WIDTH  packed word; first byte in lane NB-1 (MSBs).
be_out  out  NB  byte enables; be_out[i] covers d_out[8i+7:8i].
d_qual  out  1  d_out/be_out valid.
eof_out  out  1  high with d_qual on the final word of the frame.
bytes_out  out  32  bytes emitted this frame, including stuffing; cleared at the next frame's first accepted beat.

Behaviour:
- Reset: in_ready=0 for the reset cycle, then 1. d_out=0, be_out=0, d_qual=0, eof_out=0, bytes_out=0. Accumulator, byte stage and word assembler are cleared. Reset mid-frame discards all partial data with no output.
- Handshake: a beat transfers when in_valid&&in_ready.
  - in_ready = (acc_count <= ACC_WIDTH-MAX_CODE_LEN) && state==RUN.
  - A transferred beat appends len_in bits, MSB-first, below the existing accumulator content.
- Byte extraction: one byte per cycle when acc_count>=8 and the assembler has a free lane.
  - If the byte is 0xFF and STUFF_EN=1, the next extraction slot emits 0x00 before any further accumulator byte.
- Word assembly: bytes fill lanes NB-1 downward. When all NB lanes are filled, the word moves to the output register: d_qual=1, be_out=all ones.
- Output register:
  - A word is consumed on a cycle where d_qual && !s_halt.
  - While s_halt=1, d_out, be_out, d_qual and eof_out hold stable.
  - The assembler stalls only if it is full and the output register is occupied.
- State machine:
  - RUN → PAD when eof_in is accepted. A beat with in_valid and eof_in in the same cycle is appended first.
  - PAD: if acc_count mod 8 != 0, fill with 1s to the byte boundary (one cycle). Go to DRAIN.
  - DRAIN: extract and stuff the remaining bytes. A padded 0xFF is stuffed.
  - DRAIN → LAST when the accumulator is empty and no stuff byte is pending.
  - LAST: emit the partial word. Its lanes are the filled lanes: be_out = contiguous ones from bit NB-1. Unused lanes of d_out are 0. eof_out=1 with d_qual.
    - If the frame ended exactly on a word boundary, the last full word carries eof_out.
    - An empty frame emits one word with be_out=0 and eof_out=1.
  - LAST → RUN when the final word is consumed. in_ready is 0 during PAD, DRAIN and LAST.
- Latency: a byte completed by a beat in cycle N reaches the assembler in N+1. A word completed by its last byte is visible on d_qual the cycle after.
- Error handling: len_in > MAX_CODE_LEN is illegal; the behaviour is unspecified and is a bench assertion.

Test Plan:
1. OUT_WIDTH=32. Beats (0x12,8),(0x34,8),(0x56,8),(0x78,8), then eof -> one word d_out=0x12345678, be_out=4'b1111, eof_out=1 on that word; bytes_out=4.
2. Stuffing. Beats (0xFF,8),(0x01,8), eof -> d_out=0xFF000100, be_out=4'b1110, eof_out=1; bytes_out=3. With STUFF_EN=0: d_out=0xFF010000, be_out=4'b1100.
3. Padding. Beat (3'b101,3), eof -> d_out=0xBF000000, be_out=4'b1000, eof_out=1.
4. Pad creates 0xFF. Beat (4'b1111,4), eof -> d_out=0xFF000000, be_out=4'b1100 (stuffed 0x00 in lane 2); bytes_out=2.
5. Back-pressure. Stream 64 bytes of 0xA5 as 8-bit beats with s_halt toggled randomly -> 16 words of 0xA5A5A5A5, in order, each stable while halted. in_ready drops once the accumulator is full, and no data is lost.
6. Reset mid-frame. Assert rst after 3 bytes -> outputs are 0 next cycle. A new frame (0xAB,8)+eof yields d_out=0xAB000000, be_out=4'b1000, with no residue from the aborted frame.
